// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS sequencing controller: a Moore FSM that walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath controls.
module mips_mc_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OP,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       MEM_REQ,
  output logic       IORD,
  output logic       MEMWRITE,
  output logic       IRWRITE,
  output logic       REGDST,
  output logic       MEM2REG,
  output logic       REGWRITE,
  output logic       ALUSRCA,
  output logic [1:0] ALUSRCB,
  output logic [1:0] PCSRC,
  output logic       PC_EN,
  output logic [2:0] ALU_CONTROL,
  output logic       ILLEGAL
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam state_t     RST_STATE = state_t'(RESET_STATE);
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       funct_ok;
  logic [2:0] exec_alu;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    funct_ok = 1'b1;
    exec_alu = ALU_ADD;
    case (FUNCT)
      6'b100000: exec_alu = ALU_ADD;
      6'b100010: exec_alu = ALU_SUB;
      6'b100100: exec_alu = ALU_AND;
      6'b100101: exec_alu = ALU_OR;
      6'b101010: exec_alu = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:  if (MEM_READY) state_d = DECODE;
      DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (OP == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (MEM_READY) state_d = MEMWB;
      MEMWR:  if (MEM_READY) state_d = FETCH;
      EXEC: begin
        if (funct_ok) begin
          state_d = ALUWB;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state_q   <= RST_STATE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset forces the FETCH look with its strobes suppressed, which also kills a pending write.
  always_comb begin
    MEM_REQ     = 1'b0;
    IORD        = 1'b0;
    MEMWRITE    = 1'b0;
    IRWRITE     = 1'b0;
    REGDST      = 1'b0;
    MEM2REG     = 1'b0;
    REGWRITE    = 1'b0;
    ALUSRCA     = 1'b0;
    ALUSRCB     = 2'b00;
    PCSRC       = 2'b00;
    PC_EN       = 1'b0;
    ALU_CONTROL = ALU_ADD;
    if (RST) begin
      MEM_REQ = 1'b1;
      ALUSRCB = 2'b01;
    end else begin
      case (state_q)
        FETCH: begin
          MEM_REQ = 1'b1;
          ALUSRCB = 2'b01;
          IRWRITE = MEM_READY;
          PC_EN   = MEM_READY;
        end
        DECODE: ALUSRCB = 2'b11;
        MEMADR: begin
          ALUSRCA = 1'b1;
          ALUSRCB = 2'b10;
        end
        MEMRD: begin
          MEM_REQ = 1'b1;
          IORD    = 1'b1;
        end
        MEMWB: begin
          MEM2REG  = 1'b1;
          REGWRITE = 1'b1;
        end
        MEMWR: begin
          MEM_REQ  = 1'b1;
          IORD     = 1'b1;
          MEMWRITE = 1'b1;
        end
        EXEC: begin
          ALUSRCA     = 1'b1;
          ALU_CONTROL = exec_alu;
        end
        ALUWB: begin
          REGDST   = 1'b1;
          REGWRITE = 1'b1;
        end
        BRANCH: begin
          ALUSRCA     = 1'b1;
          ALU_CONTROL = ALU_SUB;
          PCSRC       = 2'b01;
          PC_EN       = ZERO;
        end
        ADDIEX: begin
          ALUSRCA = 1'b1;
          ALUSRCB = 2'b10;
        end
        ADDIWB: REGWRITE = 1'b1;
        JUMP: begin
          PCSRC = 2'b10;
          PC_EN = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: each instruction is expanded into its list of
// phases and expected control outputs, then compared cycle by cycle.
module tb_mips_mc_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] OP = 6'b0, FUNCT = 6'b100000;
  logic       ZERO = 1'b0, MEM_READY = 1'b1;
  logic       MEM_REQ, IORD, MEMWRITE, IRWRITE, REGDST, MEM2REG, REGWRITE, ALUSRCA, PC_EN, ILLEGAL;
  logic [1:0] ALUSRCB, PCSRC;
  logic [2:0] ALU_CONTROL;

  mips_mc_ctrl dut (
    .CLK(CLK), .RST(RST), .OP(OP), .FUNCT(FUNCT), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .MEM_REQ(MEM_REQ), .IORD(IORD), .MEMWRITE(MEMWRITE), .IRWRITE(IRWRITE),
    .REGDST(REGDST), .MEM2REG(MEM2REG), .REGWRITE(REGWRITE), .ALUSRCA(ALUSRCA),
    .ALUSRCB(ALUSRCB), .PCSRC(PCSRC), .PC_EN(PC_EN), .ALU_CONTROL(ALU_CONTROL),
    .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef enum {P_FETCH, P_DEC, P_ADDR, P_RD, P_LWB, P_WR, P_EX, P_RWB,
                P_BR, P_AEX, P_AWB, P_J, P_HALT} phase_e;

  int checks = 0, failures = 0;
  bit ill = 1'b0;
  int n_rw, n_mw, n_wb;
  logic [2:0] ex_alu;
  logic       br_pcen, rwb_rdst;
  logic [1:0] br_pcsrc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {MEM_REQ,IORD,MEMWRITE,IRWRITE,REGDST,MEM2REG,REGWRITE,ALUSRCA,ALUSRCB,PCSRC,PC_EN,ALU_CONTROL,ILLEGAL}
  function automatic logic [16:0] obs_vec();
    return {MEM_REQ, IORD, MEMWRITE, IRWRITE, REGDST, MEM2REG, REGWRITE, ALUSRCA,
            ALUSRCB, PCSRC, PC_EN, ALU_CONTROL, ILLEGAL};
  endfunction

  function automatic logic [16:0] exp_out(phase_e ph, logic rdy, logic z, logic [5:0] fn, logic il);
    logic mreq = 0, iord = 0, mw = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, sa = 0, pce = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] alu = 3'b010;
    case (ph)
      P_FETCH: begin mreq = 1; sb = 2'b01; irw = rdy; pce = rdy; end
      P_DEC:   sb = 2'b11;
      P_ADDR:  begin sa = 1; sb = 2'b10; end
      P_RD:    begin mreq = 1; iord = 1; end
      P_LWB:   begin m2r = 1; rw = 1; end
      P_WR:    begin mreq = 1; iord = 1; mw = 1; end
      P_EX: begin
        sa = 1;
        if (fn == 6'b100010) alu = 3'b110;
        else if (fn == 6'b100100) alu = 3'b000;
        else if (fn == 6'b100101) alu = 3'b001;
        else if (fn == 6'b101010) alu = 3'b111;
      end
      P_RWB:   begin rdst = 1; rw = 1; end
      P_BR:    begin sa = 1; alu = 3'b110; ps = 2'b01; pce = z; end
      P_AEX:   begin sa = 1; sb = 2'b10; end
      P_AWB:   rw = 1;
      P_J:     begin ps = 2'b10; pce = 1; end
      default: ;
    endcase
    return {mreq, iord, mw, irw, rdst, m2r, rw, sa, sb, ps, pce, alu, il};
  endfunction

  function automatic bit funct_legal(logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // One clock: drive inputs, compare at the falling edge, then cross the rising edge.
  task automatic step(input phase_e ph, input logic rdy, input logic z, input string tag);
    logic [16:0] v;
    MEM_READY = rdy;
    ZERO      = z;
    @(negedge CLK);
    v = obs_vec();
    check(tag, {15'b0, v}, {15'b0, exp_out(ph, rdy, z, FUNCT, ill)});
    n_rw += int'(REGWRITE);
    n_mw += int'(MEMWRITE & IORD & MEM_REQ);
    n_wb += int'(REGWRITE & MEM2REG);
    if (ph == P_EX)  ex_alu = ALU_CONTROL;
    if (ph == P_RWB) rwb_rdst = REGDST;
    if (ph == P_BR) begin br_pcen = PC_EN; br_pcsrc = PCSRC; end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    MEM_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("rst_irwrite%0d", i), {31'b0, IRWRITE}, 32'd0);
      check($sformatf("rst_pc_en%0d", i), {31'b0, PC_EN}, 32'd0);
      check($sformatf("rst_illegal%0d", i), {31'b0, ILLEGAL}, 32'd0);
      check($sformatf("rst_fetch_look%0d", i), {29'b0, MEM_REQ, ALUSRCB}, {29'b0, 1'b1, 2'b01});
    end
    RST = 1'b0;
    ill = 1'b0;
  endtask

  // Runs one instruction from FETCH; sf/sm are wait-state counts in FETCH and MEMRD/MEMWR.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int sf, input int sm, output bit back_in_fetch);
    phase_e q[$];
    bit bad = 1'b0;
    OP = op;
    FUNCT = fn;
    n_rw = 0; n_mw = 0; n_wb = 0;
    q = '{P_FETCH, P_DEC};
    case (op)
      6'b100011: q = {q, P_ADDR, P_RD, P_LWB};
      6'b101011: q = {q, P_ADDR, P_WR};
      6'b000000: begin
        q.push_back(P_EX);
        if (funct_legal(fn)) q.push_back(P_RWB); else bad = 1'b1;
      end
      6'b000100: q.push_back(P_BR);
      6'b001000: q = {q, P_AEX, P_AWB};
      6'b000010: q.push_back(P_J);
      default:   bad = 1'b1;
    endcase
    foreach (q[i]) begin
      bit waits = q[i] inside {P_FETCH, P_RD, P_WR};
      int nw = (q[i] == P_FETCH) ? sf : (waits ? sm : 0);
      for (int w = 0; w < nw; w++)
        step(q[i], 1'b0, 1'($urandom_range(0, 1)), $sformatf("op%b_ph%0d_wait%0d", op, i, w));
      step(q[i], waits ? 1'b1 : 1'($urandom_range(0, 1)),
           (q[i] == P_BR) ? z : 1'($urandom_range(0, 1)), $sformatf("op%b_ph%0d", op, i));
    end
    if (bad) begin
      ill = 1'b1;
      for (int h = 0; h < 20; h++)
        step(P_HALT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("halt%0d", h));
    end
    back_in_fetch = MEM_REQ && !IORD && (ALUSRCB == 2'b01);
  endtask

  initial begin
    logic [5:0] legal_ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] functs [5]    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_exp [5]   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    bit bf;

    do_reset();

    run_instr(6'b100011, 6'b0, 1'b0, 3, 2, bf);
    check("lw_stall_len10", {31'b0, bf}, 32'd1);
    check("lw_wb_once", n_wb, 1);

    run_instr(6'b101011, 6'b0, 1'b0, 0, 0, bf);
    check("sw_len4", {31'b0, bf}, 32'd1);
    check("sw_write_once", n_mw, 1);
    check("sw_no_regwrite", n_rw, 0);

    run_instr(6'b000100, 6'b0, 1'b1, 0, 0, bf);
    check("beq_taken_pc_en", {29'b0, br_pcsrc, br_pcen}, {29'b0, 2'b01, 1'b1});
    check("beq_taken_len3", {31'b0, bf}, 32'd1);
    run_instr(6'b000100, 6'b0, 1'b0, 0, 0, bf);
    check("beq_not_taken_pc_en", {31'b0, br_pcen}, 32'd0);
    check("beq_not_taken_len3", {31'b0, bf}, 32'd1);

    for (int k = 0; k < 5; k++) begin
      run_instr(6'b000000, functs[k], 1'b0, 0, 0, bf);
      check($sformatf("rtype_alu%0d", k), {29'b0, ex_alu}, {29'b0, alu_exp[k]});
      check($sformatf("rtype_regdst%0d", k), {31'b0, rwb_rdst}, 32'd1);
    end

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, functs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, bf);
      check($sformatf("rand%0d_back_in_fetch", n), {31'b0, bf}, 32'd1);
    end

    // Reset arriving while a store waits on memory must suppress the write strobe.
    OP = 6'b101011;
    step(P_FETCH, 1'b1, 1'b0, "abort_fetch");
    step(P_DEC, 1'b1, 1'b0, "abort_dec");
    step(P_ADDR, 1'b1, 1'b0, "abort_addr");
    step(P_WR, 1'b0, 1'b0, "abort_wr_wait");
    RST = 1'b1;
    MEM_READY = 1'b1;
    @(negedge CLK);
    check("abort_memwrite", {31'b0, MEMWRITE}, 32'd0);
    check("abort_vec", {15'b0, obs_vec()}, {15'b0, exp_out(P_FETCH, 1'b0, 1'b0, FUNCT, 1'b0)});
    @(posedge CLK);
    #1;
    RST = 1'b0;
    run_instr(6'b001000, 6'b0, 1'b0, 0, 0, bf);
    check("after_abort_addi", {31'b0, bf}, 32'd1);

    run_instr(6'b111111, 6'b0, 1'b0, 0, 0, bf);
    check("illegal_op_flag", {31'b0, ILLEGAL}, 32'd1);
    do_reset();
    check("illegal_cleared", {31'b0, ILLEGAL}, 32'd0);
    run_instr(6'b000000, 6'b000000, 1'b0, 1, 0, bf);
    check("illegal_funct_flag", {31'b0, ILLEGAL}, 32'd1);
    do_reset();
    run_instr(6'b000010, 6'b0, 1'b0, 2, 0, bf);
    check("jump_after_reset", {31'b0, bf}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle sequencing controller for the MIPS core. It replaces the single-cycle `controller` once the core moves to a shared instruction/data memory with a variable-latency ready handshake. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. Each state drives the datapath mux selects, register and memory write strobes, and the ALU control. The FSM also raises a sticky flag on unsupported opcodes.

## Interface
Parameters:
- `RESET_STATE`, 0 (FETCH): state entered on reset; fixed, not overridden in the core.

Ports:
- `CLK`  in  1  core clock; all state changes on rising edge
- `RST`  in  1  synchronous, active-high reset
- `OP`  in  6  instr[31:26] from the instruction register
- `FUNCT`  in  6  instr[5:0] from the instruction register
- `ZERO`  in  1  ALU zero flag
- `MEM_READY`  in  1  memory access completes this cycle
- `MEM_REQ`  out  1  memory access request
- `IORD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MEMWRITE`  out  1  memory write request, qualified by `MEM_REQ`
- `IRWRITE`  out  1  instruction register load
- `REGDST`  out  1  write-register select: 1 = rd, 0 = rt
- `MEM2REG`  out  1  write-data select: 1 = memory data, 0 = ALUOut
- `REGWRITE`  out  1  register file write enable
- `ALUSRCA`  out  1  ALU A select: 0 = PC, 1 = rs
- `ALUSRCB`  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign_imm, 11 = sign_imm<<2
- `PCSRC`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `PC_EN`  out  1  PC register load
- `ALU_CONTROL`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `ILLEGAL`  out  1  sticky flag: unsupported opcode was decoded

## Operation
States:
- FETCH
- DECODE
- MEMADR
- MEMRD
- MEMWB
- MEMWR
- EXEC
- ALUWB
- BRANCH
- ADDIEX
- ADDIWB
- JUMP
- HALT

Per-state behaviour:
- FETCH: `MEM_REQ`=1, `IORD`=0, `ALUSRCA`=0, `ALUSRCB`=01, add, `PCSRC`=00.
  - `IRWRITE` and `PC_EN` equal `MEM_READY`.
  - Stay in FETCH while `MEM_READY`=0; go to DECODE when it is 1.
- DECODE: `ALUSRCA`=0, `ALUSRCB`=11, add (branch target into ALUOut). Dispatch on `OP`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → HALT, setting `ILLEGAL`
- MEMADR: `ALUSRCA`=1, `ALUSRCB`=10, add. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `MEM_REQ`=1, `IORD`=1. Hold until `MEM_READY`, then go to MEMWB.
- MEMWB: `REGDST`=0, `MEM2REG`=1, `REGWRITE`=1, then go to FETCH.
- MEMWR: `MEM_REQ`=1, `IORD`=1, `MEMWRITE`=1. Hold until `MEM_READY`, then go to FETCH.
- EXEC: `ALUSRCA`=1, `ALUSRCB`=00. `ALU_CONTROL` decoded from `FUNCT`:
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - any other funct → go to HALT with `ILLEGAL` set; otherwise go to ALUWB.
- ALUWB: `REGDST`=1, `MEM2REG`=0, `REGWRITE`=1, then go to FETCH.
- BRANCH: `ALUSRCA`=1, `ALUSRCB`=00, sub, `PCSRC`=01, `PC_EN`=`ZERO`, then go to FETCH.
- ADDIEX: `ALUSRCA`=1, `ALUSRCB`=10, add, then go to ADDIWB.
- ADDIWB: `REGDST`=0, `MEM2REG`=0, `REGWRITE`=1, then go to FETCH.
- JUMP: `PCSRC`=10, `PC_EN`=1, then go to FETCH.
- HALT: all strobes 0. Terminal; left only through `RST`.

Default values for any output a state does not list:
- strobes (`MEM_REQ`, `MEMWRITE`, `IRWRITE`, `REGWRITE`, `PC_EN`) = 0
- selects = 0
- `ALU_CONTROL` = 010 (add)

## Timing
- All outputs are combinational from the state register. `MEM_READY` additionally gates `IRWRITE` and `PC_EN` in FETCH; `ZERO` gates `PC_EN` in BRANCH.
- Outputs carry no registered delay.
- Reset:
  - `RST` high at a rising edge puts the FSM in FETCH and clears `ILLEGAL` at that edge.
  - While `RST` is high, outputs show FETCH values with `IRWRITE`=`PC_EN`=0. The FSM ignores `MEM_READY` during reset.
  - `RST` mid-instruction (any state, including a pending MEMWR) aborts the instruction at that edge; no further strobe is issued for it.
- Latency in cycles with zero wait states (`MEM_READY` held 1):
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
- Each cycle with `MEM_READY`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `MEM_REQ`, `IORD` and `MEMWRITE` stay stable for the whole wait.
- A memory write completes exactly once, at the edge where `MEM_READY`=1.
- `ILLEGAL` rises one cycle after DECODE or EXEC detects an unsupported code, and stays high until reset.

## Test plan
- Reset: hold `RST`=1 for 2 cycles with `MEM_READY`=1, then release. During reset `IRWRITE`=`PC_EN`=0, `ILLEGAL`=0. The first post-reset cycle shows FETCH with `IRWRITE`=`PC_EN`=1 and `ALUSRCB`=01.
- lw with memory stalls:
  - Stimulus: `OP`=100011; `MEM_READY`=0 for 3 cycles in FETCH and 2 cycles in MEMRD.
  - Required: total 10 cycles to the next FETCH; `REGWRITE`=1 with `MEM2REG`=1 for exactly one cycle.
- sw: `OP`=101011 with `MEM_READY`=1 → 4 cycles; `MEMWRITE`=1 with `IORD`=1 for exactly one cycle; `REGWRITE` never asserted.
- beq: `OP`=000100.
  - `ZERO`=1 → `PC_EN`=1 with `PCSRC`=01 in BRANCH.
  - `ZERO`=0 → `PC_EN`=0.
  - Both cases return to FETCH after 3 cycles.
- R-type decode: `OP`=000000 with `FUNCT` = 100000, 100010, 100100, 100101, 101010 in turn.
  - Required `ALU_CONTROL` in EXEC: 010, 110, 000, 001, 111.
  - `REGDST`=1 in ALUWB.
- Illegal codes:
  - `OP`=111111 → HALT and `ILLEGAL`=1, with no strobes for 20 cycles.
  - `RST` then clears `ILLEGAL`; `FUNCT`=000000 on R-type then also reaches HALT.
